regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the 32-bit register file among N_REQ writeback sources (e.g. ALU, load unit, vector unit).
- Drives the register file's WriteEn/RegIn through a registered output stage.
- Supports locked bursts so a multi-register writer (e.g. a vector load) holds the port for consecutive cycles.
- Sits between the writeback stage and the register file.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 4, register address width.
- DATA_W, 32, write data width.
- MAX_LOCK, 8, maximum consecutive transfers in one locked burst (1..255).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester write request.
- req_lock  input  N_REQ  requester wants to keep the port after this transfer.
- req_addr  input  N_REQ*ADDR_W  packed destination addresses; requester i in slice i.
- req_data  input  N_REQ*DATA_W  packed write data.
- req_ready  output  N_REQ  combinational; one-hot or zero.
- wr_en  output  1  register file WriteEn.
- wr_addr  output  ADDR_W  register file write address.
- wr_data  output  DATA_W  register file RegIn.
- grant_id  output  $clog2(N_REQ)  requester index of the current wr_en beat.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, rr_ptr=0, state=ARB, lock_cnt=0.
- While reset is high, req_ready=0.
- Handshake: transfer occurs on an edge where req_valid[i] & req_ready[i].
- Latency: exactly 1 cycle from handshake to wr_en=1 with the captured addr/data/grant_id.
- wr_en is a single-cycle pulse per transfer. With no transfer, wr_en=0 and wr_addr, wr_data, grant_id hold.
- ARB state:
  - Winner g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[g]=1, all others 0; all 0 if no valid.
  - On handshake: rr_ptr <= (g+1) mod N_REQ.
  - If req_lock[g]=1 at handshake: state <= LOCKED, owner <= g, lock_cnt <= 1.
- LOCKED state:
  - req_ready[owner]=1 unconditionally; all others 0, even if valid.
  - Owner dropping valid keeps the lock (no transfer, no timeout).
  - Each owner handshake increments lock_cnt.
  - Exit to ARB when a handshake has req_lock[owner]=0, or when that handshake makes lock_cnt reach MAX_LOCK (forced release).
  - On exit: rr_ptr <= (owner+1) mod N_REQ.
- Simultaneous valid from all requesters gives strict rotation; no requester waits more than N_REQ-1 grants, or N_REQ-1 bursts when locks are used.
- Reset mid-burst: next edge returns to ARB, rr_ptr=0, wr_en=0. An in-flight captured beat is discarded.
- Requesters must hold addr/data/valid stable until handshake; the arbiter does not check this.
- State encoding: ARB=0, LOCKED=1.

Optional Feature:
- Macro: REGFILE_ZERO_PROTECT_EN.
- Defined: a handshake with req_addr=0 completes normally (ready, rr_ptr and lock_cnt update as usual) but wr_en stays 0 the next cycle; wr_addr, wr_data and grant_id hold. Register 0 is never written.
- Undefined: address 0 is treated like any other address.

Decomposition:
- Package regfile_arb_pkg: typedef arb_state_t {ARB, LOCKED}; localparams for default ADDR_W/DATA_W; function rr_pick (rotating priority encoder).
- Sub-module rr_priority_enc (valid vector + pointer -> one-hot grant + index) is natural and reusable by other arbiters.
- The FSM, lock counter and output register stay in the top.

Test Plan:
- Reset then idle: all req_valid=0 for 5 cycles -> wr_en=0, wr_addr=0, wr_data=0, req_ready=0.
- Single request: req_valid=3'b010, addr=4'h5, data=32'hff -> req_ready=3'b010 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hff, grant_id=1.
- Contention: req_valid=3'b111 held for 6 cycles, data 32'hA0/A1/A2 -> grant_id sequence 0,1,2,0,1,2; one wr_en pulse per cycle.
- Locked burst: req1 lock=1 for 3 beats (data 32'hfc, 32'hfd, 32'hfe), lock=0 on the 4th beat (32'hff), req0 valid throughout -> req0 ready=0 for 4 cycles; grant_id=1 x4, then 0.
- Forced release: MAX_LOCK=2, req2 lock held with req0 valid -> after 2 beats of req2, req0 is granted.
- Reset mid-burst: assert reset during the 2nd locked beat -> next cycle wr_en=0, state ARB. After release with req_valid=3'b111, the first grant_id=0.
- With REGFILE_ZERO_PROTECT_EN: req0 addr=0, data=32'hfc -> handshake occurs but wr_en stays 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arb_pkg
// Purpose  : Shared types and the rotating priority pick for the register
//            file write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int c_default_addr_w = 4;
    localparam int c_default_data_w = 32;
    localparam int c_max_req        = 8;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0] scanning ptr, ptr+1, ... modulo n.
    function automatic rr_pick_t rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < c_max_req; k++) begin
            j = (int'(ptr) + k) % n;
            if ((k < n) && !r.found && valid[3'(j)]) begin
                r.found = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter_if
// Purpose  : Writeback requester bus plus register file write port.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    localparam int c_ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [c_ID_W-1:0]       grant_id;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, grant_id
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_enc
// Purpose  : Rotating priority encoder: valid vector + pointer -> one-hot
//            grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_enc
    import regfile_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     i_valid,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant,
    output logic      [IDX_W-1:0] o_grant_idx
);

    rr_pick_t w_pick;

    assign w_pick      = rr_pick(8'(i_valid), 3'(i_ptr), N);
    assign o_grant     = w_pick.found ? (N'(1) << w_pick.idx) : '0;
    assign o_grant_idx = IDX_W'(w_pick.idx);

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Round-robin arbiter with locked bursts for the register file
//            write port. Optional macro REGFILE_ZERO_PROTECT_EN suppresses
//            writes to register 0.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = c_default_addr_w,
    parameter int DATA_W   = c_default_data_w,
    parameter int MAX_LOCK = 8
) (
    input wire logic          clk,
    input wire logic          reset,
    regfile_wr_arbiter_if.slave bus
);

    localparam int              c_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]      c_MAX_LOCK = 8'(MAX_LOCK);

    arb_state_t          r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_owner;
    logic [7:0]          r_lock_cnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [c_IDX_W-1:0]  r_grant_id;

    logic [N_REQ-1:0]    w_enc_grant;
    logic [c_IDX_W-1:0]  w_enc_idx;
    logic [N_REQ-1:0]    w_ready;
    logic [c_IDX_W-1:0]  w_sel;
    logic                w_hs;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_lock;
    logic                w_zero_block;
    logic [7:0]          w_cnt_next;

    function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + c_IDX_W'(1);
    endfunction

    rr_priority_enc #(
        .N     (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_enc (
        .i_valid     (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_enc_grant),
        .o_grant_idx (w_enc_idx)
    );

    // A locked owner keeps its ready even while it is not presenting valid.
    always_comb begin
        w_ready = '0;
        if (!reset) begin
            w_ready = (r_state == LOCKED) ? (N_REQ'(1) << r_owner) : w_enc_grant;
        end
    end

    assign w_sel      = (r_state == LOCKED) ? r_owner : w_enc_idx;
    assign w_hs       = |(bus.req_valid & w_ready);
    assign w_cnt_next = r_lock_cnt + 8'd1;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == c_IDX_W'(i)) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
                w_sel_lock = bus.req_lock[i];
            end
        end
    end

`ifdef REGFILE_ZERO_PROTECT_EN
    assign w_zero_block = (w_sel_addr == '0);
`else
    assign w_zero_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_hs) begin
                if (!w_zero_block) begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= w_sel_addr;
                    r_wr_data  <= w_sel_data;
                    r_grant_id <= w_sel;
                end
                case (r_state)
                    ARB: begin
                        r_rr_ptr <= next_idx(w_sel);
                        // A single-beat burst limit means a lock never takes hold.
                        if (w_sel_lock && (MAX_LOCK > 1)) begin
                            r_state    <= LOCKED;
                            r_owner    <= w_sel;
                            r_lock_cnt <= 8'd1;
                        end
                    end
                    LOCKED: begin
                        if (!w_sel_lock || (w_cnt_next == c_MAX_LOCK)) begin
                            r_state    <= ARB;
                            r_rr_ptr   <= next_idx(r_owner);
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= w_cnt_next;
                        end
                    end
                    default: r_state <= ARB;
                endcase
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Directed self-checking bench for regfile_wr_arbiter
//            (default MAX_LOCK and MAX_LOCK=2 instances; REGFILE_ZERO_PROTECT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.N_REQ(3), .ADDR_W(4), .DATA_W(32)) bus  ();
    regfile_wr_arbiter_if #(.N_REQ(3), .ADDR_W(4), .DATA_W(32)) bus2 ();

    regfile_wr_arbiter #(.N_REQ(3), .ADDR_W(4), .DATA_W(32), .MAX_LOCK(8)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    regfile_wr_arbiter #(.N_REQ(3), .ADDR_W(4), .DATA_W(32), .MAX_LOCK(2)) u_dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2)
    );

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [3:0] a, input logic [31:0] d);
        bus.req_valid[i]         = v;
        bus.req_lock[i]          = l;
        bus.req_addr[i*4 +: 4]   = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic set_req2(input int i, input logic v, input logic l,
                            input logic [3:0] a, input logic [31:0] d);
        bus2.req_valid[i]         = v;
        bus2.req_lock[i]          = l;
        bus2.req_addr[i*4 +: 4]   = a;
        bus2.req_data[i*32 +: 32] = d;
    endtask

    task automatic clear_all();
        bus.req_valid  = '0;
        bus.req_lock   = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus2.req_valid = '0;
        bus2.req_lock  = '0;
        bus2.req_addr  = '0;
        bus2.req_data  = '0;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_all();
        rst = 1'b1;
        bus.req_valid = 3'b111;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready_in_reset: got %b expected 000", bus.req_ready);
        end
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_wr_en cycle %0d: got %b expected 0", k, bus.wr_en);
            end
            n_checks++;
            if (bus.wr_addr !== 4'h0 || bus.wr_data !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_addr_data cycle %0d: got %h/%h expected 0/0", k, bus.wr_addr, bus.wr_data);
            end
            n_checks++;
            if (bus.req_ready !== 3'b000 || bus.grant_id !== 2'd0) begin
                n_fail++;
                $display("FAIL idle_ready_gid cycle %0d: got %b/%0d expected 000/0", k, bus.req_ready, bus.grant_id);
            end
        end
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 1'b0, 4'h5, 32'hff);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 010", bus.req_ready);
        end
        @(posedge clk);
        #1 set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'h5 || bus.wr_data !== 32'hff || bus.grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL single_write: got en=%b a=%h d=%h g=%0d expected 1/5/ff/1",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'h5 || bus.wr_data !== 32'hff || bus.grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL single_hold: got en=%b a=%h d=%h g=%0d expected 0/5/ff/1",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_d;
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'h1, 32'hA0);
        set_req(1, 1'b1, 1'b0, 4'h2, 32'hA1);
        set_req(2, 1'b1, 1'b0, 4'h3, 32'hA2);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            exp_d = 32'hA0 + 32'(k % 3);
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'(k % 3) || bus.wr_data !== exp_d) begin
                n_fail++;
                $display("FAIL contention beat %0d: got en=%b g=%0d d=%h expected 1/%0d/%h",
                         k, bus.wr_en, bus.grant_id, bus.wr_data, k % 3, exp_d);
            end
            if (k == 5) bus.req_valid = '0;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_idle: got %b expected 0", bus.wr_en);
        end
    endtask

    task automatic test_locked_burst();
        do_reset();
        // One req0 transfer moves the pointer to req1.
        set_req(0, 1'b1, 1'b0, 4'h7, 32'h55);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                set_req(1, 1'b0, 1'b1, 4'h9, 32'h0);
                #1;
                n_checks++;
                if (bus.req_ready !== 3'b010) begin
                    n_fail++;
                    $display("FAIL lock_owner_idle_ready: got %b expected 010", bus.req_ready);
                end
                @(posedge clk);
                #1;
                n_checks++;
                if (bus.wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_owner_idle_wr_en: got %b expected 0", bus.wr_en);
                end
            end
            set_req(1, 1'b1, (k < 3), 4'h9, 32'hfc + 32'(k));
            #1;
            n_checks++;
            if (bus.req_ready !== 3'b010) begin
                n_fail++;
                $display("FAIL lock_ready beat %0d: got %b expected 010", k, bus.req_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd1 || bus.wr_data !== 32'hfc + 32'(k)) begin
                n_fail++;
                $display("FAIL lock_beat %0d: got en=%b g=%0d d=%h expected 1/1/%h",
                         k, bus.wr_en, bus.grant_id, bus.wr_data, 32'hfc + 32'(k));
            end
        end
        set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL lock_release_ready: got %b expected 001", bus.req_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd0 || bus.wr_data !== 32'h55) begin
            n_fail++;
            $display("FAIL lock_release_grant: got en=%b g=%0d d=%h expected 1/0/55",
                     bus.wr_en, bus.grant_id, bus.wr_data);
        end
        clear_all();
    endtask

    task automatic test_forced_release();
        do_reset();
        set_req2(0, 1'b1, 1'b0, 4'h1, 32'h10);
        @(posedge clk);
        #1;
        set_req2(2, 1'b1, 1'b1, 4'h2, 32'hc0);
        for (int k = 0; k < 2; k++) begin
            bus2.req_data[64 +: 32] = 32'hc0 + 32'(k);
            #1;
            n_checks++;
            if (bus2.req_ready !== 3'b100) begin
                n_fail++;
                $display("FAIL forced_ready beat %0d: got %b expected 100", k, bus2.req_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus2.wr_en !== 1'b1 || bus2.grant_id !== 2'd2 || bus2.wr_data !== 32'hc0 + 32'(k)) begin
                n_fail++;
                $display("FAIL forced_beat %0d: got en=%b g=%0d d=%h expected 1/2/%h",
                         k, bus2.wr_en, bus2.grant_id, bus2.wr_data, 32'hc0 + 32'(k));
            end
        end
        n_checks++;
        if (bus2.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL forced_release_ready: got %b expected 001", bus2.req_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus2.wr_en !== 1'b1 || bus2.grant_id !== 2'd0 || bus2.wr_data !== 32'h10) begin
            n_fail++;
            $display("FAIL forced_release_grant: got en=%b g=%0d d=%h expected 1/0/10",
                     bus2.wr_en, bus2.grant_id, bus2.wr_data);
        end
        clear_all();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'h3, 32'hd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL midburst_ready_in_reset: got %b expected 000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midburst_reset_out: got en=%b d=%h expected 0/0", bus.wr_en, bus.wr_data);
        end
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'h1, 32'hE0);
        set_req(1, 1'b1, 1'b0, 4'h2, 32'hE1);
        set_req(2, 1'b1, 1'b0, 4'h3, 32'hE2);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL midburst_after_ready: got %b expected 001", bus.req_ready);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'(k)) begin
                n_fail++;
                $display("FAIL midburst_after_grant %0d: got en=%b g=%0d expected 1/%0d",
                         k, bus.wr_en, bus.grant_id, k);
            end
        end
        clear_all();
    endtask

    task automatic test_zero_addr();
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'h0, 32'hfc);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL zero_ready: got %b expected 001", bus.req_ready);
        end
        @(posedge clk);
        #1;
`ifdef REGFILE_ZERO_PROTECT_EN
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_data !== 32'h0 || bus.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL zero_protect: got en=%b d=%h g=%0d expected 0/0/0",
                     bus.wr_en, bus.wr_data, bus.grant_id);
        end
`else
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'h0 || bus.wr_data !== 32'hfc) begin
            n_fail++;
            $display("FAIL zero_normal: got en=%b a=%h d=%h expected 1/0/fc",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
`endif
        // The pointer must have advanced past req0 either way.
        set_req(1, 1'b1, 1'b0, 4'h4, 32'h44);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL zero_ptr_advance: got %b expected 010", bus.req_ready);
        end
        clear_all();
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single();
        test_contention();
        test_locked_burst();
        test_forced_release();
        test_reset_midburst();
        test_zero_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
